stack_exec_unit: RTL and testbench
==================================

// Module: stack_exec_unit
// PURPOSE
//  Parametrised successor to the stack-processor control/data-memory integration block.
//  - Executes one stack-machine instruction per accepted handshake against an internal
//    operand stack (STACK_DEPTH entries) and an internal word-addressed data memory.
//  - Owns the PC register.
//  - Adds valid/ready flow control, a load-wait state for memory reads, ALU ops, and a
//    sticky fault state for overflow, underflow and illegal opcodes.
// PARAMETERS
//  WIDTH        16   data, instruction and PC width; opcode = inst[WIDTH-1:WIDTH-4], imm = inst[WIDTH-5:0]
//  STACK_DEPTH  16   operand stack entries (>=2)
//  MEM_AW       8    data memory address bits; address = imm[MEM_AW-1:0], 2**MEM_AW words
//  PC_RESET     0    newPC value after reset
// PORTS
//  CLK             in   1               rising-edge clock
//  reset           in   1               asynchronous, active-low reset
//  inst            in   WIDTH           instruction word
//  inst_valid      in   1               inst is presented
//  inst_ready      out  1               unit can accept inst this cycle
//  getinData       in   WIDTH           external input value pushed by getin
//  clear_fault     in   1               leave FAULT state (one-cycle pulse)
//  newPC           out  WIDTH           program counter
//  stackWriteData  out  WIDTH           last value written onto the stack
//  stack_top       out  WIDTH           current top of stack; 0 when empty
//  stack_count     out  $clog2(STACK_DEPTH+1)  occupied entries
//  fault           out  1               sticky fault flag
//  fault_code      out  2               01 overflow, 10 underflow, 11 illegal opcode
// BEHAVIOUR
//  Reset (async assert, low)
//  - Outputs: newPC=PC_RESET; stackWriteData, stack_top, stack_count, fault, fault_code all 0.
//  - State=RUN. Any LOAD in progress is aborted. Memory contents are retained.
//  Handshake
//  - An instruction is accepted on a rising edge with inst_valid && inst_ready.
//  - All effects of an accepted instruction are visible after that edge.
//  - inst_ready=1 only in RUN.
//  States: RUN, LOAD, FAULT.
//  Opcodes (16-bit examples)
//  - 0x0 funct = imm[3:0]:
//    - 0 nop.
//    - 1 add: pop b, pop a, push a+b.
//    - 2 sub: push a-b.
//    - 4 getin: push getinData.
//    - 5 drop: pop, discard.
//  - 0x3 j: newPC <= imm<<1, truncated to WIDTH. Example: 0x3005 -> newPC=0x000A.
//  - 0x5 pop a: mem[a] <= top; pop.
//  - 0x6 push a:
//    - Accept edge N: issue synchronous read, go to LOAD (ready=0).
//    - Edge N+1: push mem[a], return to RUN. Two-cycle latency.
//  - 0x7 pushi: push zero-extended imm. Example: 0x7003 -> 0x0003.
//  - 0x8 lui: push (imm << (WIDTH-4)) mod 2**WIDTH. Example: 0x8003 -> 0x3000.
//  - Any other opcode or funct is illegal.
//  PC
//  - Every accepted, non-faulting, non-j instruction does newPC <= newPC+2, wrapping mod 2**WIDTH.
//  - push increments the PC at edge N.
//  Stack writes
//  - Every push and every ALU result updates stackWriteData and stack_top.
//  - pop and drop leave stackWriteData unchanged.
//  - ALU results wrap mod 2**WIDTH. add/sub reduce stack_count by 1.
//  Faults
//  - Overflow: a push-type op when stack_count==STACK_DEPTH. Code 01.
//  - Underflow: pop/drop with count<1, or add/sub with count<2. Code 10.
//  - Illegal opcode: code 11.
//  - A faulting instruction changes nothing else (stack, memory and PC unchanged).
//  - On a fault: fault=1, state -> FAULT.
//  - In FAULT: clear_fault=1 at an edge -> RUN, fault and fault_code return to 0, stack preserved.
//  - clear_fault is ignored in RUN and LOAD.
//  - The overflow check for push is made at accept time; LOAD is never entered when the stack is full.
//  - Full stack: pop or add is legal; nop is legal and does not fault.
// TESTING
//  1. reset low mid-LOAD (after accepting 0x6005)
//     -> all outputs at reset values, inst_ready=1 after release, no push occurs.
//  2. getinData=0x13, inst=0x0004
//     -> stackWriteData=0x0013, count=1.
//     Then 0x3005 -> newPC=0x000A.
//     Then 0x8003 -> 0x3000. Then 0x7003 -> 0x0003.
//  3. pushi 7, pushi 5, add -> top=0x000C, count=1.
//     Then pushi 0x00F, sub -> top=0xFFFD.
//  4. pushi 0x333, pop 2, push 2
//     -> inst_ready=0 for exactly one cycle, then stackWriteData=0x0333.
//  5. STACK_DEPTH pushi, then one more pushi
//     -> fault=1, code=01, count=STACK_DEPTH, PC unchanged, inst_ready=0.
//     clear_fault -> RUN, contents intact.
//  6. Empty stack, pop 1 -> fault code 10, mem[1] unchanged.
//     After clear, inst=0xF000 -> fault code 11.

Source files
------------

// File: rtl/stack_exec_unit_if.sv
// Instruction handshake bundle between an instruction source and stack_exec_unit.
//   inst        instruction word (source -> unit)
//   inst_valid  inst is presented (source -> unit)
//   inst_ready  unit can accept inst this cycle (unit -> source)
interface stack_exec_unit_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] inst;
    logic             inst_valid;
    logic             inst_ready;

    modport master (
        output inst,
        output inst_valid,
        input  inst_ready
    );

    modport slave (
        input  inst,
        input  inst_valid,
        output inst_ready
    );
endinterface

// File: rtl/stack_exec_unit.sv
// Stack-machine execution unit: one instruction per accepted handshake against an
// internal operand stack and word-addressed data memory, with PC, load-wait and a
// sticky fault state.
//   CLK, reset      clock, asynchronous active-low reset
//   bus             instruction handshake (slave side)
//   getinData       value pushed by getin
//   clear_fault     leaves FAULT when pulsed
//   newPC           program counter
//   stackWriteData  last value written onto the stack
//   stack_top       current top of stack, 0 when empty
//   stack_count     occupied stack entries
//   fault           sticky fault flag
//   fault_code      01 overflow, 10 underflow, 11 illegal opcode
module stack_exec_unit #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned STACK_DEPTH = 16,
    parameter int unsigned MEM_AW      = 8,
    parameter int unsigned PC_RESET    = 0
) (
    input  logic                                  CLK,
    input  logic                                  reset,
    stack_exec_unit_if.slave                      bus,
    input  logic [WIDTH-1:0]                      getinData,
    input  logic                                  clear_fault,
    output logic [WIDTH-1:0]                      newPC,
    output logic [WIDTH-1:0]                      stackWriteData,
    output logic [WIDTH-1:0]                      stack_top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]      stack_count,
    output logic                                  fault,
    output logic [1:0]                            fault_code
);
    localparam int unsigned CW    = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned IMMW  = WIDTH - 4;
    localparam int unsigned MEMSZ = 2 ** MEM_AW;

    localparam logic [3:0] OP_ALU   = 4'h0;
    localparam logic [3:0] OP_J     = 4'h3;
    localparam logic [3:0] OP_POPM  = 4'h5;
    localparam logic [3:0] OP_PUSHM = 4'h6;
    localparam logic [3:0] OP_PUSHI = 4'h7;
    localparam logic [3:0] OP_LUI   = 4'h8;

    localparam logic [3:0] FN_NOP   = 4'd0;
    localparam logic [3:0] FN_ADD   = 4'd1;
    localparam logic [3:0] FN_SUB   = 4'd2;
    localparam logic [3:0] FN_GETIN = 4'd4;
    localparam logic [3:0] FN_DROP  = 4'd5;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVF  = 2'b01;
    localparam logic [1:0] FC_UNF  = 2'b10;
    localparam logic [1:0] FC_ILL  = 2'b11;

    typedef enum logic [1:0] {RUN, LOAD, FAULT} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  top_q, top_d;
    logic [WIDTH-1:0]  swd_q, swd_d;
    logic              fault_q, fault_d;
    logic [1:0]        code_q, code_d;
    logic              ready_q, ready_d;

    logic [WIDTH-1:0]  stk [STACK_DEPTH];
    logic [WIDTH-1:0]  mem [MEMSZ];
    logic [WIDTH-1:0]  rd_q;

    logic              stk_we;
    logic [IW-1:0]     stk_widx;
    logic [WIDTH-1:0]  stk_wdata;
    logic              mem_we;
    logic              mem_rd;

    logic [3:0]        op;
    logic [IMMW-1:0]   imm;
    logic [3:0]        funct;
    logic [MEM_AW-1:0] mem_addr;
    logic              full;
    logic [WIDTH-1:0]  below;
    logic [1:0]        code_c;
    logic              push_c;
    logic [WIDTH-1:0]  push_val;

    assign op       = bus.inst[WIDTH-1:WIDTH-4];
    assign imm      = bus.inst[IMMW-1:0];
    assign funct    = imm[3:0];
    assign mem_addr = imm[MEM_AW-1:0];
    assign full     = (cnt_q == CW'(STACK_DEPTH));
    // Entry under the top: ALU operand a, and the new top after a pop.
    assign below    = (cnt_q >= CW'(2)) ? stk[IW'(cnt_q - CW'(2))] : '0;

    // Next-state, datapath control and output update.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        top_d     = top_q;
        swd_d     = swd_q;
        fault_d   = fault_q;
        code_d    = code_q;
        stk_we    = 1'b0;
        stk_widx  = '0;
        stk_wdata = '0;
        mem_we    = 1'b0;
        mem_rd    = 1'b0;
        code_c    = FC_NONE;
        push_c    = 1'b0;
        push_val  = '0;

        unique case (state_q)
            RUN: begin
                if (bus.inst_valid) begin
                    // Fault classification happens before any side effect.
                    unique case (op)
                        OP_ALU: begin
                            unique case (funct)
                                FN_NOP:         code_c = FC_NONE;
                                FN_ADD, FN_SUB: if (cnt_q < CW'(2)) code_c = FC_UNF;
                                FN_GETIN:       if (full) code_c = FC_OVF;
                                FN_DROP:        if (cnt_q < CW'(1)) code_c = FC_UNF;
                                default:        code_c = FC_ILL;
                            endcase
                        end
                        OP_J:                         code_c = FC_NONE;
                        OP_POPM:                      if (cnt_q < CW'(1)) code_c = FC_UNF;
                        OP_PUSHM, OP_PUSHI, OP_LUI:   if (full) code_c = FC_OVF;
                        default:                      code_c = FC_ILL;
                    endcase

                    if (code_c != FC_NONE) begin
                        fault_d = 1'b1;
                        code_d  = code_c;
                        state_d = FAULT;
                    end else begin
                        pc_d = pc_q + WIDTH'(2);
                        unique case (op)
                            OP_ALU: begin
                                if (funct == FN_ADD || funct == FN_SUB) begin
                                    stk_we    = 1'b1;
                                    stk_widx  = IW'(cnt_q - CW'(2));
                                    stk_wdata = (funct == FN_ADD) ? below + top_q : below - top_q;
                                    cnt_d     = cnt_q - CW'(1);
                                    top_d     = stk_wdata;
                                    swd_d     = stk_wdata;
                                end else if (funct == FN_GETIN) begin
                                    push_c   = 1'b1;
                                    push_val = getinData;
                                end else if (funct == FN_DROP) begin
                                    cnt_d = cnt_q - CW'(1);
                                    top_d = below;
                                end
                            end
                            OP_J:     pc_d = WIDTH'({imm, 1'b0});
                            OP_POPM: begin
                                mem_we = 1'b1;
                                cnt_d  = cnt_q - CW'(1);
                                top_d  = below;
                            end
                            OP_PUSHM: begin
                                mem_rd  = 1'b1;
                                state_d = LOAD;
                            end
                            OP_PUSHI: begin
                                push_c   = 1'b1;
                                push_val = WIDTH'(imm);
                            end
                            OP_LUI: begin
                                push_c   = 1'b1;
                                push_val = WIDTH'({imm, {(WIDTH-4){1'b0}}});
                            end
                            default: ;
                        endcase
                    end
                end
            end
            LOAD: begin
                // Overflow was ruled out when the load was accepted.
                push_c   = 1'b1;
                push_val = rd_q;
                state_d  = RUN;
            end
            FAULT: begin
                if (clear_fault) begin
                    state_d = RUN;
                    fault_d = 1'b0;
                    code_d  = FC_NONE;
                end
            end
            default: state_d = RUN;
        endcase

        if (push_c) begin
            stk_we    = 1'b1;
            stk_widx  = IW'(cnt_q);
            stk_wdata = push_val;
            cnt_d     = cnt_q + CW'(1);
            top_d     = push_val;
            swd_d     = push_val;
        end

        ready_d = (state_d == RUN);
    end

    // Control and output registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= WIDTH'(PC_RESET);
            cnt_q   <= '0;
            top_q   <= '0;
            swd_q   <= '0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            top_q   <= top_d;
            swd_q   <= swd_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            ready_q <= ready_d;
        end
    end

    // Storage arrays; contents survive reset.
    always_ff @(posedge CLK) begin
        if (stk_we) stk[stk_widx] <= stk_wdata;
        if (mem_we) mem[mem_addr] <= top_q;
        if (mem_rd) rd_q <= mem[mem_addr];
    end

    assign bus.inst_ready = ready_q;
    assign newPC          = pc_q;
    assign stackWriteData = swd_q;
    assign stack_top      = top_q;
    assign stack_count    = cnt_q;
    assign fault          = fault_q;
    assign fault_code     = code_q;
endmodule

// File: tb/tb_stack_exec_unit.sv
module tb_stack_exec_unit;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 16;

    logic              CLK;
    logic              reset;
    logic [WIDTH-1:0]  getinData;
    logic              clear_fault;
    logic [WIDTH-1:0]  newPC;
    logic [WIDTH-1:0]  stackWriteData;
    logic [WIDTH-1:0]  stack_top;
    logic [4:0]        stack_count;
    logic              fault;
    logic [1:0]        fault_code;

    int                vectors;
    int                miscompares;
    logic [WIDTH-1:0]  exp_pc;

    stack_exec_unit_if #(.WIDTH(WIDTH)) bus ();

    stack_exec_unit #(
        .WIDTH(WIDTH), .STACK_DEPTH(DEPTH), .MEM_AW(8), .PC_RESET(0)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .bus(bus),
        .getinData(getinData),
        .clear_fault(clear_fault),
        .newPC(newPC),
        .stackWriteData(stackWriteData),
        .stack_top(stack_top),
        .stack_count(stack_count),
        .fault(fault),
        .fault_code(fault_code)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction once the unit is ready; returns 1ns after the accept edge.
    task automatic issue(input logic [WIDTH-1:0] i);
        int n;
        n = 0;
        @(negedge CLK);
        while (bus.inst_ready !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("ready_wait", 32'(n < 20), 32'd1);
        bus.inst       = i;
        bus.inst_valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.inst_valid = 1'b0;
    endtask

    task automatic issue_ok(input logic [WIDTH-1:0] i);
        issue(i);
        exp_pc = exp_pc + 16'd2;
    endtask

    task automatic pulse_clear();
        @(negedge CLK);
        clear_fault = 1'b1;
        @(posedge CLK);
        #1;
        clear_fault = 1'b0;
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        exp_pc         = 16'h0000;
        reset          = 1'b0;
        getinData      = '0;
        clear_fault    = 1'b0;
        bus.inst       = '0;
        bus.inst_valid = 1'b0;

        #1;
        check("rst_pc",    32'(newPC),          32'h0);
        check("rst_swd",   32'(stackWriteData), 32'h0);
        check("rst_top",   32'(stack_top),      32'h0);
        check("rst_cnt",   32'(stack_count),    32'h0);
        check("rst_fault", 32'(fault),          32'h0);
        check("rst_code",  32'(fault_code),     32'h0);
        repeat (2) @(negedge CLK);
        reset = 1'b1;

        // Reset in the middle of a memory load
        issue_ok(16'h6005);
        check("load_ready", 32'(bus.inst_ready), 32'h0);
        check("load_pc",    32'(newPC),          32'h2);
        #2;
        reset = 1'b0;
        #1;
        exp_pc = 16'h0000;
        check("midrst_pc",    32'(newPC),          32'h0);
        check("midrst_swd",   32'(stackWriteData), 32'h0);
        check("midrst_top",   32'(stack_top),      32'h0);
        check("midrst_cnt",   32'(stack_count),    32'h0);
        check("midrst_fault", 32'(fault),          32'h0);
        @(negedge CLK);
        reset = 1'b1;
        check("midrst_ready", 32'(bus.inst_ready), 32'h1);
        @(posedge CLK);
        #1;
        check("midrst_nopush", 32'(stack_count),   32'h0);
        check("midrst_ready2", 32'(bus.inst_ready), 32'h1);

        // getin, j, lui, pushi
        getinData = 16'h0013;
        issue_ok(16'h0004);
        check("getin_swd", 32'(stackWriteData), 32'h0013);
        check("getin_cnt", 32'(stack_count),    32'h1);
        check("getin_pc",  32'(newPC),          32'(exp_pc));
        issue(16'h3005);
        exp_pc = 16'h000A;
        check("j_pc", 32'(newPC), 32'h000A);
        issue_ok(16'h8003);
        check("lui_swd", 32'(stackWriteData), 32'h3000);
        check("lui_top", 32'(stack_top),      32'h3000);
        issue_ok(16'h7003);
        check("pushi_swd", 32'(stackWriteData), 32'h0003);
        check("pushi_cnt", 32'(stack_count),    32'h3);
        check("pushi_pc",  32'(newPC),          32'h000E);
        issue_ok(16'h0005);
        check("drop_swd", 32'(stackWriteData), 32'h0003);
        check("drop_top", 32'(stack_top),      32'h3000);
        issue_ok(16'h0005);
        issue_ok(16'h0005);
        check("drop_empty_top", 32'(stack_top),   32'h0);
        check("drop_empty_cnt", 32'(stack_count), 32'h0);
        check("drop_pc",        32'(newPC),       32'h0014);

        // ALU
        issue_ok(16'h7007);
        issue_ok(16'h7005);
        issue_ok(16'h0001);
        check("add_top", 32'(stack_top),   32'h000C);
        check("add_cnt", 32'(stack_count), 32'h1);
        issue_ok(16'h700F);
        issue_ok(16'h0002);
        check("sub_top", 32'(stack_top),      32'hFFFD);
        check("sub_swd", 32'(stackWriteData), 32'hFFFD);
        check("sub_cnt", 32'(stack_count),    32'h1);
        issue_ok(16'h0005);

        // Store to memory then load back
        issue_ok(16'h7333);
        issue_ok(16'h5002);
        check("popm_cnt", 32'(stack_count),    32'h0);
        check("popm_swd", 32'(stackWriteData), 32'h0333);
        issue_ok(16'h6002);
        check("pushm_ready0", 32'(bus.inst_ready), 32'h0);
        check("pushm_cnt0",   32'(stack_count),    32'h0);
        @(posedge CLK);
        #1;
        check("pushm_ready1", 32'(bus.inst_ready), 32'h1);
        check("pushm_swd",    32'(stackWriteData), 32'h0333);
        check("pushm_cnt1",   32'(stack_count),    32'h1);
        check("pushm_pc",     32'(newPC),          32'(exp_pc));
        issue_ok(16'h0005);

        // Fill the stack, overflow, recover
        for (int i = 0; i < int'(DEPTH); i++) issue_ok(16'(16'h7000 + i));
        check("full_cnt", 32'(stack_count), 32'(DEPTH));
        check("full_top", 32'(stack_top),   32'h000F);
        issue_ok(16'h0000);
        check("full_nop_fault", 32'(fault), 32'h0);
        check("full_nop_pc",    32'(newPC), 32'(exp_pc));
        issue(16'h7099);
        check("ovf_fault", 32'(fault),          32'h1);
        check("ovf_code",  32'(fault_code),     32'h1);
        check("ovf_cnt",   32'(stack_count),    32'(DEPTH));
        check("ovf_pc",    32'(newPC),          32'(exp_pc));
        check("ovf_ready", 32'(bus.inst_ready), 32'h0);
        check("ovf_top",   32'(stack_top),      32'h000F);
        pulse_clear();
        check("clr_fault", 32'(fault),          32'h0);
        check("clr_code",  32'(fault_code),     32'h0);
        check("clr_ready", 32'(bus.inst_ready), 32'h1);
        check("clr_cnt",   32'(stack_count),    32'(DEPTH));
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            check("unwind_top", 32'(stack_top), 32'(k));
            issue_ok(16'h0005);
        end
        check("unwind_cnt", 32'(stack_count), 32'h0);
        check("unwind_top0", 32'(stack_top),  32'h0);

        // Underflow leaves memory alone
        issue_ok(16'h70AB);
        issue_ok(16'h5001);
        issue(16'h5001);
        check("unf_fault", 32'(fault),       32'h1);
        check("unf_code",  32'(fault_code),  32'h2);
        check("unf_pc",    32'(newPC),       32'(exp_pc));
        check("unf_cnt",   32'(stack_count), 32'h0);
        pulse_clear();
        issue_ok(16'h6001);
        @(posedge CLK);
        #1;
        check("mem1_kept", 32'(stack_top), 32'h00AB);
        issue_ok(16'h0005);

        // Illegal opcode and illegal funct
        issue(16'hF000);
        check("ill_fault", 32'(fault),      32'h1);
        check("ill_code",  32'(fault_code), 32'h3);
        check("ill_pc",    32'(newPC),      32'(exp_pc));
        pulse_clear();
        issue(16'h0003);
        check("illfn_code", 32'(fault_code), 32'h3);
        pulse_clear();

        // add with a single operand underflows
        issue_ok(16'h7001);
        issue(16'h0001);
        check("addunf_code", 32'(fault_code),  32'h2);
        check("addunf_cnt",  32'(stack_count), 32'h1);
        check("addunf_top",  32'(stack_top),   32'h1);
        pulse_clear();
        check("final_fault", 32'(fault), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
